feature_row_fetch: RTL and testbench
====================================

FEATURE_ROW_FETCH -- requirements
Module: feature_row_fetch

Interface
REQ-001 Parameters SHALL be: Tn, default `Tn, input-channel parallelism; KERNEL_SIZE, default `KERNEL_SIZE, maximum kernel rows; ADDR_WIDTH, default 10, feature-buffer row-address width.
REQ-002 Ports SHALL be: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-003 Ports SHALL be: start  in  1  one-cycle job launch; kernel_size  in  8  kernel rows K; stride  in  4  row stride S; fm_rows  in  8  output rows R; buf_sel  in  1  ping-pong half; row_base_addr  in  ADDR_WIDTH  first row address.
REQ-004 Ports SHALL be: vreg_enable  out  1  row push to the vertical register; vreg_in_select  out  1  buffer half select; rd_addr  out  ADDR_WIDTH  feature-buffer row address; shift_done  in  1  per-row shift completion from the vertical register.
REQ-005 Ports SHALL be: window_valid  out  1  full K-row window ready; window_ack  in  1  consumer accepted window; busy  out  1  job active; done  out  1  one-cycle job completion; err  out  1  illegal configuration flag.

Function
REQ-006 start SHALL latch kernel_size, stride, fm_rows, buf_sel and row_base_addr only in IDLE; start outside IDLE SHALL be ignored.
REQ-007 FSM states SHALL be IDLE, ISSUE, DRAIN, PRESENT, FINISH.
REQ-008 IDLE->ISSUE on start when R>0; when R=0, IDLE->FINISH directly.
REQ-009 In ISSUE, vreg_enable SHALL be high for N consecutive cycles, where N=K for window 0 and N=min(S,K) for later windows; then ISSUE->DRAIN.
REQ-010 rd_addr SHALL equal row_base_addr+row_idx in every vreg_enable cycle; row_idx starts at 0 and increments by 1 per enable, wrapping modulo 2^ADDR_WIDTH.
REQ-011 When S>K, row_idx SHALL advance by S-K without enables before each later window, so window w starts at row w*S.
REQ-012 vreg_in_select SHALL equal the latched buf_sel for the whole job.
REQ-013 DRAIN SHALL count shift_done pulses, including pulses arriving during ISSUE, and move to PRESENT when the count reaches N.
REQ-014 In PRESENT, window_valid SHALL stay high until the cycle window_ack is sampled high. On acceptance, the FSM SHALL move to ISSUE for the next window, or to FINISH after window R-1.
REQ-015 FINISH SHALL pulse done for exactly one cycle and return to IDLE.
REQ-016 busy SHALL be high in every state except IDLE.
REQ-017 window_ack outside PRESENT SHALL be ignored.

Reset
REQ-018 rst SHALL force IDLE and SHALL clear row_idx, window count and shift_done count.
REQ-019 On rst, vreg_enable, vreg_in_select, rd_addr, window_valid, busy, done and err SHALL go to 0, including when rst arrives mid-job.

Configuration
REQ-020 With macro ROW_FETCH_ERR_CHECK_EN defined, K=0, K>KERNEL_SIZE or S=0 at start SHALL set err, issue no enables, and go to FINISH. err SHALL stay high until the next legal start or rst.
REQ-021 Without ROW_FETCH_ERR_CHECK_EN, err SHALL be tied 0, K SHALL be clamped to [1,KERNEL_SIZE], and S SHALL be clamped to a minimum of 1.

Structure
REQ-022 The FSM state encoding and the ADDR_WIDTH default SHALL reside in the shared network parameter header alongside Tn and KERNEL_SIZE.
REQ-023 One sub-module, row_counter, SHALL provide the reusable row_idx/window counter; everything else SHALL be flat.

Verification
REQ-024 K=3, S=1, R=2, base=0x010, buf_sel=1, with a shift_done model at 3-cycle latency and ack 1 cycle after valid: enables at addr 0x010..0x012 then 0x013; two window_valids; vreg_in_select=1; done once.
REQ-025 K=3, S=5, R=2, base=0: window 1 enables at rows 5,6,7; rows 3,4 are skipped with no enable.
REQ-026 window_ack held low for 20 cycles: window_valid stays high for 20 cycles and no enables are issued meanwhile.
REQ-027 rst asserted mid-ISSUE of window 1: the next cycle shows all outputs 0 and IDLE; a fresh start then runs normally from row_base_addr.
REQ-028 base=0x3FF, K=3 (ADDR_WIDTH=10): rd_addr sequence is 0x3FF, 0x000, 0x001.
REQ-029 With ROW_FETCH_ERR_CHECK_EN: K=0 gives err=1, zero enables and done after 2 cycles. Without the macro: K=0 runs as K=1 with err=0.

Source files
------------

// File: rtl/feature_row_fetch_pkg.sv
// Shared network parameter header for the feature-row fetch path.
// Holds the network-wide defaults (Tn, KERNEL_SIZE), the feature-buffer
// row-address width default and the fetch FSM state encoding.
// Optional feature macro used by the fetch block: ROW_FETCH_ERR_CHECK_EN.

`ifndef Tn
`define Tn 16
`endif

`ifndef KERNEL_SIZE
`define KERNEL_SIZE 11
`endif

package feature_row_fetch_pkg;

   localparam int unsigned TN_DEFAULT          = `Tn;
   localparam int unsigned KERNEL_SIZE_DEFAULT = `KERNEL_SIZE;
   localparam int unsigned ADDR_WIDTH_DEFAULT  = 10;

   localparam int unsigned CFG_WIDTH    = 8;
   localparam int unsigned STRIDE_WIDTH = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_PRESENT = 3'd3,
      ST_FINISH  = 3'd4
   } fetch_state_t;

   // Rows pushed for a later window: only the rows not already held over.
   function automatic logic [CFG_WIDTH-1:0] later_rows(input logic [CFG_WIDTH-1:0]    k,
                                                       input logic [STRIDE_WIDTH-1:0] s);
      logic [CFG_WIDTH-1:0] s_w;
      s_w = CFG_WIDTH'(s);
      return (s_w < k) ? s_w : k;
   endfunction

endpackage

// File: rtl/feature_row_fetch_row_counter.sv
// Reusable row/window counter for the feature-row fetch block.
// Ports: clk, rst (sync active-high); clr restarts both counts; row_step_en
// adds row_step to row_idx (wraps modulo 2^ADDR_WIDTH); win_inc bumps win_idx.
// clr and a step in the same cycle yield the step applied from zero.

module feature_row_fetch_row_counter #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned WIN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  row_step_en,
   input  logic [ADDR_WIDTH-1:0] row_step,
   input  logic                  win_inc,
   output logic [ADDR_WIDTH-1:0] row_idx,
   output logic [WIN_WIDTH-1:0]  win_idx
);

   // Counter state; clear and step may coincide on job launch.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_idx <= '0;
         win_idx <= '0;
      end else begin
         row_idx <= (clr ? '0 : row_idx) + (row_step_en ? row_step : '0);
         win_idx <= (clr ? '0 : win_idx) + WIN_WIDTH'(win_inc);
      end
   end

endmodule

// File: rtl/feature_row_fetch.sv
// Feature-row fetch controller: streams K-row windows from the feature buffer
// into the vertical register, waits for the shifts to land, presents each
// window to the consumer and repeats for R output rows.
// Ports: clk, rst (sync active-high); start + job config (kernel_size,
// stride, fm_rows, buf_sel, row_base_addr); vreg_enable/vreg_in_select/
// rd_addr row pushes; shift_done back-pressure; window_valid/window_ack
// handshake; busy, done, err status.
// Macro ROW_FETCH_ERR_CHECK_EN: reject illegal K/S with err instead of clamping.

module feature_row_fetch
   import feature_row_fetch_pkg::*;
#(
   parameter int unsigned Tn          = TN_DEFAULT,
   parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_DEFAULT,
   parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [CFG_WIDTH-1:0]    kernel_size,
   input  logic [STRIDE_WIDTH-1:0] stride,
   input  logic [CFG_WIDTH-1:0]    fm_rows,
   input  logic                    buf_sel,
   input  logic [ADDR_WIDTH-1:0]   row_base_addr,
   output logic                    vreg_enable,
   output logic                    vreg_in_select,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   input  logic                    shift_done,
   output logic                    window_valid,
   input  logic                    window_ack,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   // Row fetch is channel-agnostic; Tn is carried for a uniform network interface.
   if (Tn == 0) begin : g_tn_unsupported
   end

   fetch_state_t              state_q;
   logic [CFG_WIDTH-1:0]      k_q;
   logic [STRIDE_WIDTH-1:0]   s_q;
   logic [CFG_WIDTH-1:0]      r_q;
   logic [CFG_WIDTH-1:0]      n_q;
   logic [CFG_WIDTH-1:0]      iss_cnt_q;
   logic [CFG_WIDTH-1:0]      sd_cnt_q;
   logic [ADDR_WIDTH-1:0]     base_q;

   logic [CFG_WIDTH-1:0]      k_eff;
   logic [STRIDE_WIDTH-1:0]   s_eff;
   logic                      cfg_bad;
   logic [ADDR_WIDTH-1:0]     skip;
   logic [CFG_WIDTH:0]        sd_total;
   logic                      last_win;

   logic                      cnt_clr;
   logic                      row_step_en;
   logic [ADDR_WIDTH-1:0]     row_step;
   logic                      win_inc;
   logic [ADDR_WIDTH-1:0]     row_idx;
   logic [CFG_WIDTH-1:0]      win_idx;

`ifdef ROW_FETCH_ERR_CHECK_EN
   assign cfg_bad = (kernel_size == '0) || (kernel_size > CFG_WIDTH'(KERNEL_SIZE)) ||
                    (stride == '0);
   assign k_eff   = kernel_size;
   assign s_eff   = stride;
`else
   assign cfg_bad = 1'b0;
   assign k_eff   = (kernel_size == '0) ? CFG_WIDTH'(1) :
                    (kernel_size > CFG_WIDTH'(KERNEL_SIZE)) ? CFG_WIDTH'(KERNEL_SIZE) :
                    kernel_size;
   assign s_eff   = (stride == '0) ? STRIDE_WIDTH'(1) : stride;
   assign err     = 1'b0;
`endif

   // Rows between the end of one window's rows and the start of the next (S>K only).
   assign skip     = (CFG_WIDTH'(s_q) > k_q) ? ADDR_WIDTH'(CFG_WIDTH'(s_q) - k_q) : '0;
   assign sd_total = {1'b0, sd_cnt_q} + (CFG_WIDTH+1)'(shift_done);
   assign last_win = (win_idx == (r_q - CFG_WIDTH'(1)));

   // Counter controls track the same transitions the FSM takes below.
   always_comb begin
      cnt_clr     = 1'b0;
      row_step_en = 1'b0;
      row_step    = '0;
      win_inc     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_clr = 1'b1;
               if (!cfg_bad && (fm_rows != '0)) begin
                  row_step_en = 1'b1;
                  row_step    = ADDR_WIDTH'(1);
               end
            end
         end
         ST_ISSUE: begin
            if (iss_cnt_q != n_q) begin
               row_step_en = 1'b1;
               row_step    = ADDR_WIDTH'(1);
            end
         end
         ST_PRESENT: begin
            if (window_ack) begin
               win_inc = 1'b1;
               if (!last_win) begin
                  row_step_en = 1'b1;
                  row_step    = skip + ADDR_WIDTH'(1);
               end
            end
         end
         default: ;
      endcase
   end

   feature_row_fetch_row_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WIN_WIDTH  (CFG_WIDTH)
   ) row_counter (
      .clk         (clk),
      .rst         (rst),
      .clr         (cnt_clr),
      .row_step_en (row_step_en),
      .row_step    (row_step),
      .win_inc     (win_inc),
      .row_idx     (row_idx),
      .win_idx     (win_idx)
   );

   // Fetch FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         k_q            <= '0;
         s_q            <= '0;
         r_q            <= '0;
         n_q            <= '0;
         iss_cnt_q      <= '0;
         sd_cnt_q       <= '0;
         base_q         <= '0;
         vreg_enable    <= 1'b0;
         vreg_in_select <= 1'b0;
         rd_addr        <= '0;
         window_valid   <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
`ifdef ROW_FETCH_ERR_CHECK_EN
         err            <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  k_q            <= k_eff;
                  s_q            <= s_eff;
                  r_q            <= fm_rows;
                  n_q            <= k_eff;
                  base_q         <= row_base_addr;
                  vreg_in_select <= buf_sel;
                  iss_cnt_q      <= CFG_WIDTH'(1);
                  sd_cnt_q       <= '0;
                  busy           <= 1'b1;
`ifdef ROW_FETCH_ERR_CHECK_EN
                  err            <= cfg_bad;
`endif
                  if (cfg_bad || (fm_rows == '0)) begin
                     state_q <= ST_FINISH;
                     done    <= 1'b1;
                  end else begin
                     state_q     <= ST_ISSUE;
                     vreg_enable <= 1'b1;
                     rd_addr     <= row_base_addr;
                  end
               end
            end
            ST_ISSUE: begin
               // Shifts from early rows can complete while later rows still issue.
               sd_cnt_q <= CFG_WIDTH'(sd_total);
               if (iss_cnt_q == n_q) begin
                  vreg_enable <= 1'b0;
                  state_q     <= ST_DRAIN;
               end else begin
                  rd_addr   <= base_q + row_idx;
                  iss_cnt_q <= iss_cnt_q + CFG_WIDTH'(1);
               end
            end
            ST_DRAIN: begin
               sd_cnt_q <= CFG_WIDTH'(sd_total);
               if (sd_total >= {1'b0, n_q}) begin
                  state_q      <= ST_PRESENT;
                  window_valid <= 1'b1;
               end
            end
            ST_PRESENT: begin
               if (window_ack) begin
                  window_valid <= 1'b0;
                  if (last_win) begin
                     state_q <= ST_FINISH;
                     done    <= 1'b1;
                  end else begin
                     state_q     <= ST_ISSUE;
                     vreg_enable <= 1'b1;
                     rd_addr     <= base_q + row_idx + skip;
                     n_q         <= later_rows(k_q, s_q);
                     iss_cnt_q   <= CFG_WIDTH'(1);
                     sd_cnt_q    <= '0;
                  end
               end
            end
            ST_FINISH: begin
               done           <= 1'b0;
               busy           <= 1'b0;
               vreg_in_select <= 1'b0;
               state_q        <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_feature_row_fetch.sv
// Directed bench for feature_row_fetch: expected row addresses are queued
// from an independent window model at launch and popped on every enable.

module tb_feature_row_fetch;

   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    kernel_size = '0;
   logic [3:0]    stride = '0;
   logic [7:0]    fm_rows = '0;
   logic          buf_sel = 1'b0;
   logic [AW-1:0] row_base_addr = '0;
   logic          vreg_enable;
   logic          vreg_in_select;
   logic [AW-1:0] rd_addr;
   logic          shift_done = 1'b0;
   logic          window_valid;
   logic          window_ack = 1'b0;
   logic          busy;
   logic          done;
   logic          err;

   always #5 clk = ~clk;

   feature_row_fetch #(.ADDR_WIDTH(AW)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .kernel_size    (kernel_size),
      .stride         (stride),
      .fm_rows        (fm_rows),
      .buf_sel        (buf_sel),
      .row_base_addr  (row_base_addr),
      .vreg_enable    (vreg_enable),
      .vreg_in_select (vreg_in_select),
      .rd_addr        (rd_addr),
      .shift_done     (shift_done),
      .window_valid   (window_valid),
      .window_ack     (window_ack),
      .busy           (busy),
      .done           (done),
      .err            (err)
   );

   int total = 0;
   int bad   = 0;

   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] exp_addr;
   logic          exp_sel = 1'b0;
   logic [2:0]    sd_pipe = '0;
   int n_en = 0, n_win = 0, n_done = 0, n_extra = 0, en_in_valid = 0;
   int valid_len = 0, last_valid_len = 0;
   int ack_delay = 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, expv);
      end
   endtask

   // Scoreboard pop, 3-cycle shift_done model and consumer ack model.
   always @(negedge clk) begin
      if (rst) begin
         sd_pipe    = '0;
         shift_done = 1'b0;
         window_ack = 1'b0;
         valid_len  = 0;
      end else begin
         if (vreg_enable) begin
            n_en++;
            if (window_valid) en_in_valid++;
            if (exp_q.size() == 0) begin
               n_extra++;
            end else begin
               exp_addr = exp_q.pop_front();
               chk("rd_addr", 32'(rd_addr), 32'(exp_addr));
               chk("vreg_in_select", 32'(vreg_in_select), 32'(exp_sel));
            end
         end
         if (done) n_done++;
         sd_pipe    = {sd_pipe[1:0], vreg_enable};
         shift_done = sd_pipe[2];
         if (window_valid) begin
            if (valid_len == 0) n_win++;
            window_ack = (valid_len >= ack_delay);
            valid_len++;
         end else begin
            if (valid_len != 0) last_valid_len = valid_len;
            valid_len  = 0;
            window_ack = 1'b0;
         end
      end
   end

   // Window w covers rows w*S..w*S+K-1; only the last n of them are new.
   task automatic push_expect(input int k, input int s, input int r, input int base);
      for (int w = 0; w < r; w++) begin
         int n;
         n = (w == 0) ? k : ((s < k) ? s : k);
         for (int j = k - n; j < k; j++)
            exp_q.push_back(AW'(base + w * s + j));
      end
   endtask

   task automatic clear_counts();
      n_en = 0; n_win = 0; n_done = 0; n_extra = 0; en_in_valid = 0; last_valid_len = 0;
   endtask

   task automatic launch(input logic [7:0] k, input logic [3:0] s, input logic [7:0] r,
                         input logic [AW-1:0] base, input logic b);
      @(negedge clk);
      kernel_size = k; stride = s; fm_rows = r; row_base_addr = base; buf_sel = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic wait_done(input int budget);
      int c;
      c = 0;
      while (n_done == 0 && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      chk("done_within_budget", 32'(n_done != 0), 32'd1);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic post_checks(input int exp_win);
      chk("done_pulses", 32'(n_done), 32'd1);
      chk("windows", 32'(n_win), 32'(exp_win));
      chk("rows_left", 32'(exp_q.size()), 32'd0);
      chk("extra_enables", 32'(n_extra), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("err_clear", 32'(err), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_vreg_enable"}, 32'(vreg_enable), 32'd0);
      chk({tag, "_in_select"}, 32'(vreg_in_select), 32'd0);
      chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
      chk({tag, "_window_valid"}, 32'(window_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      int c;
      bit found;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // K=3 S=1 R=2 base 0x010 on buffer half 1
      clear_counts(); exp_sel = 1'b1;
      push_expect(3, 1, 2, 'h010);
      launch(8'd3, 4'd1, 8'd2, 10'h010, 1'b1);
      wait_done(500);
      post_checks(2);
      chk("enables_k3s1", 32'(n_en), 32'd4);

      // K=3 S=5 R=2: rows 3,4 skipped; a start during the job is ignored
      clear_counts(); exp_sel = 1'b0;
      push_expect(3, 5, 2, 0);
      launch(8'd3, 4'd5, 8'd2, 10'h000, 1'b0);
      @(negedge clk);
      kernel_size = 8'd1; row_base_addr = 10'h100; buf_sel = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(500);
      post_checks(2);
      chk("enables_k3s5", 32'(n_en), 32'd6);

      // Consumer stalls: window_valid holds and nothing is issued meanwhile
      clear_counts(); exp_sel = 1'b0; ack_delay = 20;
      push_expect(2, 2, 1, 'h040);
      launch(8'd2, 4'd2, 8'd1, 10'h040, 1'b0);
      wait_done(500);
      post_checks(1);
      chk("valid_hold_len", 32'(last_valid_len), 32'd21);
      chk("enables_while_valid", 32'(en_in_valid), 32'd0);
      ack_delay = 1;

      // Address wrap at the top of the buffer
      clear_counts(); exp_sel = 1'b1;
      push_expect(3, 1, 1, 'h3FF);
      launch(8'd3, 4'd1, 8'd1, 10'h3FF, 1'b1);
      wait_done(500);
      post_checks(1);

      // Reset in the middle of window 1's row issue
      clear_counts(); exp_sel = 1'b1;
      push_expect(3, 3, 3, 'h080);
      launch(8'd3, 4'd3, 8'd3, 10'h080, 1'b1);
      found = 1'b0;
      c = 0;
      while (!found && c < 500) begin
         @(posedge clk); #1;
         c++;
         if (n_win == 1 && vreg_enable === 1'b1 && window_valid === 1'b0) found = 1'b1;
      end
      chk("reached_window1_issue", 32'(found), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_all_zero("mid_job_reset");
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      clear_counts(); exp_sel = 1'b0;
      push_expect(3, 1, 1, 'h080);
      launch(8'd3, 4'd1, 8'd1, 10'h080, 1'b0);
      wait_done(500);
      post_checks(1);

      // R=0: straight to completion
      clear_counts();
      launch(8'd3, 4'd1, 8'd0, 10'h020, 1'b0);
      wait_done(10);
      post_checks(0);
      chk("enables_r0", 32'(n_en), 32'd0);

`ifdef ROW_FETCH_ERR_CHECK_EN
      // Illegal K rejected; a legal start afterwards clears err
      clear_counts();
      launch(8'd0, 4'd1, 8'd1, 10'h050, 1'b0);
      wait_done(10);
      chk("err_on_k0", 32'(err), 32'd1);
      chk("enables_k0", 32'(n_en), 32'd0);
      chk("done_k0", 32'(n_done), 32'd1);
      clear_counts(); exp_sel = 1'b0;
      push_expect(1, 1, 1, 'h050);
      launch(8'd1, 4'd1, 8'd1, 10'h050, 1'b0);
      wait_done(500);
      post_checks(1);
`else
      // K=0 clamps to 1, S=0 clamps to 1
      clear_counts(); exp_sel = 1'b0;
      push_expect(1, 1, 1, 'h050);
      launch(8'd0, 4'd1, 8'd1, 10'h050, 1'b0);
      wait_done(500);
      post_checks(1);
      clear_counts(); exp_sel = 1'b1;
      push_expect(2, 1, 2, 'h060);
      launch(8'd2, 4'd0, 8'd2, 10'h060, 1'b1);
      wait_done(500);
      post_checks(2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
